store_buffer_ctrl: RTL
======================

Name: store_buffer_ctrl

Overview:
Pointer and drain controller for the 8-entry store buffer that sits between dispatch and the data cache.
- Allocates up to two store slots per cycle to dispatch, and tracks ROB commit of stores.
- Rolls back speculative allocations on flush.
- Drains committed stores to the dcache in order, using a req/gnt/done handshake.
- Supplies the write/read pointers and the store_exe_num value consumed by dispatch and the AGU reservation station.

Parameters:
SB_DEPTH, 8, number of store buffer entries (power of two)
PTR_W, 4, pointer width = log2(SB_DEPTH)+1; the MSB is the wrap bit

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
alloc_valid  input  1  dispatch requests store slots this cycle
alloc_cnt  input  2  number of stores in the dispatch pair (0..2)
alloc_ok  output  1  slots granted this cycle (combinational)
sb_write_point  output  PTR_W  next slot to allocate (registered)
sb_commit_point  output  PTR_W  oldest uncommitted allocated slot (registered)
sb_read_point  output  PTR_W  oldest committed, undrained slot (registered)
sb_free_cnt  output  PTR_W  free entries, 0..SB_DEPTH
store_exe_num  output  5  {1'b0, sb_read_point}; the store currently eligible to execute/drain
commit_cnt  input  2  stores retired by the ROB this cycle (0..2)
flush  input  1  mispredict/exception flush; discards uncommitted stores
dc_req  output  1  drain request to the dcache (registered)
dc_idx  output  PTR_W-1  buffer index being drained
dc_gnt  input  1  dcache accepted the request
dc_done  input  1  dcache write completed
sb_empty  output  1  write point equals read point
drain_busy  output  1  drain FSM not in IDLE

Behaviour:
- Reset (reset==0, asynchronous):
  - all pointers = 0; FSM = IDLE
  - dc_req = 0, dc_idx = 0
  - sb_free_cnt = 8, sb_empty = 1, drain_busy = 0
- Pointer arithmetic:
  - all pointer arithmetic is modulo 2^PTR_W
  - occupancy = wp - rp; sb_free_cnt = SB_DEPTH - occupancy
  - full when (wp ^ rp) == 4'b1000; empty when wp == rp
- Allocation:
  - alloc_ok = alloc_valid & ~flush & (alloc_cnt <= sb_free_cnt)
  - when alloc_ok, next wp = wp + alloc_cnt; otherwise wp holds
  - alloc_cnt = 0 with alloc_valid = 1 gives alloc_ok = 1 with no pointer change
- Commit:
  - cp <= cp + commit_cnt
  - commit_cnt must never exceed wp - cp (enforced by assertion)
- Flush:
  - commit for the same cycle is applied first, then wp <= cp + commit_cnt
  - any allocation in the flush cycle is dropped (alloc_ok = 0)
  - rp and the drain FSM are unaffected, because committed stores must still drain
- Drain FSM, states IDLE, REQ, WAIT:
  - IDLE: if cp != rp, go to REQ next cycle and set dc_req = 1, dc_idx = rp[2:0].
  - REQ: hold dc_req = 1 and a stable dc_idx until dc_gnt; on dc_gnt, drop dc_req and go to WAIT.
  - WAIT: on dc_done, rp <= rp + 1. If committed entries remain (cp_next != rp + 1), go to REQ with dc_idx = (rp + 1)[2:0]; otherwise go to IDLE.
- Drain latency and throughput:
  - first request is 1 cycle after the commit is visible
  - minimum of 2 cycles per drained store
- Simultaneous events:
  - alloc, commit and drain retire in the same cycle all apply; free-count is computed from the registered pointers, so a retire frees space only from the next cycle
  - dc_gnt and dc_done together in REQ: treat as gnt only; dc_done is valid only in WAIT
- store_exe_num tracks rp and changes only on dc_done.
- sb_empty and drain_busy are combinational from the registered state.

Decomposition:
- Shared package (sb_pkg): SB_DEPTH, PTR_W, the drain_state_t enum {IDLE, REQ, WAIT}, and a ptr_t typedef.
- One natural sub-module: sb_drain_fsm, holding the state register, dc_req/dc_idx and the rp increment.
- Pointers and allocation logic stay in the top module.

Test Plan:
- Reset with reset=0 mid-drain (in WAIT) -> next cycle: all pointers 0, dc_req=0, sb_free_cnt=8, drain_busy=0.
- Allocate 2 per cycle for 4 cycles (no commit) -> wp=8, sb_free_cnt=0, wp^rp=4'b1000. A 5th request with alloc_cnt=1 -> alloc_ok=0; one more try with alloc_cnt=0 -> alloc_ok=1 and wp unchanged.
- Allocate 3, commit 2, flush in the same cycle as commit of 0 -> wp rolls back to 2, cp=2, rp=0; drain issues dc_idx=0 then dc_idx=1, then returns to IDLE with sb_empty=1.
- Wrap-around: with rp=wp=6, allocate 2, 2, 2 and commit all -> wp=4'b1100; drains occur in index order 6, 7, 0, 1, 2, 3; store_exe_num steps 6, 7, 8, ..., 11 on each dc_done.
- dc_gnt held low for 5 cycles -> dc_req stays 1 with a stable dc_idx; once gnt is given, dc_done 3 cycles later increments rp exactly once.
- Flush while the FSM is in WAIT with 2 committed entries pending -> rp is not disturbed; both committed entries still drain; uncommitted allocations are discarded (sb_free_cnt restored).

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer pointer/drain controller.
// Pointers carry one extra wrap bit above the entry index.
package sb_pkg;

    localparam int SB_DEPTH = 8;
    localparam int PTR_W    = 4;
    localparam int IDX_W    = PTR_W - 1;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } drain_state_t;

    function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
        return p + {{(PTR_W-2){1'b0}}, n};
    endfunction

    function automatic logic [IDX_W-1:0] ptr_idx(input ptr_t p);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/sb_ctrl_checker.sv
// Protocol checks on the pointer relationships of the store buffer controller.
module sb_ctrl_checker
    import sb_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    input logic [PTR_W-1:0] wp,
    input logic [PTR_W-1:0] cp,
    input logic [PTR_W-1:0] rp,
    input logic [1:0]       commit_cnt
);

    logic [PTR_W-1:0] uncommitted_s, occupancy_s;

    always_comb begin
        uncommitted_s = wp - cp;
        occupancy_s   = wp - rp;
    end

    a_commit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({{(PTR_W-2){1'b0}}, commit_cnt} <= uncommitted_s))
        else $error("sb_ctrl_checker: commit_cnt exceeds uncommitted entries");

    a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
        (occupancy_s <= PTR_W'(SB_DEPTH)))
        else $error("sb_ctrl_checker: occupancy exceeds buffer depth");

endmodule

// File: rtl/sb_drain_fsm.sv
// In-order drain of committed store buffer entries to the dcache over a
// req/gnt/done handshake; owns the read pointer.
module sb_drain_fsm
    import sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PTR_W-1:0] cp,
    input  logic [PTR_W-1:0] cp_next,
    input  logic             dc_gnt,
    input  logic             dc_done,
    output logic [PTR_W-1:0] rp,
    output logic             dc_req,
    output logic [IDX_W-1:0] dc_idx,
    output logic             busy
);

    drain_state_t     state_q, state_d;
    logic [PTR_W-1:0] rp_q, rp_d, rp_inc_s;
    logic             dc_req_q, dc_req_d;
    logic [IDX_W-1:0] dc_idx_q, dc_idx_d;

    // State, read pointer and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rp_q     <= {PTR_W{1'b0}};
            dc_req_q <= 1'b0;
            dc_idx_q <= {IDX_W{1'b0}};
        end else begin
            state_q  <= state_d;
            rp_q     <= rp_d;
            dc_req_q <= dc_req_d;
            dc_idx_q <= dc_idx_d;
        end
    end

    // Next-state logic; a done seen in REQ is ignored, only WAIT retires
    always_comb begin
        state_d  = state_q;
        rp_d     = rp_q;
        dc_req_d = dc_req_q;
        dc_idx_d = dc_idx_q;
        rp_inc_s = ptr_add(rp_q, 2'd1);
        case (state_q)
            IDLE: begin
                if (cp != rp_q) begin
                    state_d  = REQ;
                    dc_req_d = 1'b1;
                    dc_idx_d = ptr_idx(rp_q);
                end else begin
                    state_d  = IDLE;
                    dc_req_d = 1'b0;
                end
            end
            REQ: begin
                if (dc_gnt) begin
                    state_d  = WAIT;
                    dc_req_d = 1'b0;
                end else begin
                    state_d  = REQ;
                    dc_req_d = 1'b1;
                end
            end
            WAIT: begin
                if (dc_done) begin
                    rp_d = rp_inc_s;
                    // Commits landing this cycle count, so back-to-back drains need no IDLE bubble
                    if (cp_next != rp_inc_s) begin
                        state_d  = REQ;
                        dc_req_d = 1'b1;
                        dc_idx_d = ptr_idx(rp_inc_s);
                    end else begin
                        state_d  = IDLE;
                        dc_req_d = 1'b0;
                    end
                end else begin
                    state_d  = WAIT;
                    dc_req_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                dc_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rp     = rp_q;
        dc_req = dc_req_q;
        dc_idx = dc_idx_q;
        busy   = (state_q != IDLE);
    end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store buffer pointer controller: allocation, commit tracking, flush
// rollback and in-order drain to the dcache.
module store_buffer_ctrl
    import sb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [1:0]       alloc_cnt,
    output logic             alloc_ok,
    output logic [PTR_W-1:0] sb_write_point,
    output logic [PTR_W-1:0] sb_commit_point,
    output logic [PTR_W-1:0] sb_read_point,
    output logic [PTR_W-1:0] sb_free_cnt,
    output logic [4:0]       store_exe_num,
    input  logic [1:0]       commit_cnt,
    input  logic             flush,
    output logic             dc_req,
    output logic [IDX_W-1:0] dc_idx,
    input  logic             dc_gnt,
    input  logic             dc_done,
    output logic             sb_empty,
    output logic             drain_busy
);

    logic [PTR_W-1:0] wp_q, wp_d, cp_q, cp_d;
    logic [PTR_W-1:0] rp_s, occ_s, free_s;
    logic             alloc_ok_s;

    // Write and commit pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q <= {PTR_W{1'b0}};
            cp_q <= {PTR_W{1'b0}};
        end else begin
            wp_q <= wp_d;
            cp_q <= cp_d;
        end
    end

    // Free space uses registered pointers, so a drain frees space one cycle later
    always_comb begin
        occ_s      = wp_q - rp_s;
        free_s     = PTR_W'(SB_DEPTH) - occ_s;
        alloc_ok_s = alloc_valid & ~flush & ({{(PTR_W-2){1'b0}}, alloc_cnt} <= free_s);
        cp_d       = ptr_add(cp_q, commit_cnt);
        if (flush) begin
            wp_d = cp_d;
        end else if (alloc_ok_s) begin
            wp_d = ptr_add(wp_q, alloc_cnt);
        end else begin
            wp_d = wp_q;
        end
    end

    sb_drain_fsm u_drain (
        .clk     (clk),
        .rst_n   (reset),
        .cp      (cp_q),
        .cp_next (cp_d),
        .dc_gnt  (dc_gnt),
        .dc_done (dc_done),
        .rp      (rp_s),
        .dc_req  (dc_req),
        .dc_idx  (dc_idx),
        .busy    (drain_busy)
    );

    sb_ctrl_checker u_chk (
        .clk        (clk),
        .rst_n      (reset),
        .wp         (wp_q),
        .cp         (cp_q),
        .rp         (rp_s),
        .commit_cnt (commit_cnt)
    );

    always_comb begin
        alloc_ok        = alloc_ok_s;
        sb_write_point  = wp_q;
        sb_commit_point = cp_q;
        sb_read_point   = rp_s;
        sb_free_cnt     = free_s;
        store_exe_num   = {1'b0, rp_s};
        sb_empty        = (wp_q == rp_s);
    end

endmodule
